hud_card_addr_gen: RTL

- Parametrised, pipelined successor of the HUD flag/card address generator.
- Maps the VGA pixel position (h_cnt, v_cnt) to a BRAM texture address for NUM_PLAYERS rows of NUM_SLOTS cards. Each slot shows the left or right image of a shared 2-image texture strip.
- Adds three things the old block lacked: per-slot image masks, frame-synchronous mask latching (no tearing), and an optional per-player card-flip reveal animation.
- Sits between the VGA timing counter and the card BRAM; the pixel mux consumes its outputs.

---
 rtl/hud_card_addr_gen_pkg.sv | 30 +++
 rtl/hud_card_addr_gen_if.sv | 35 +++
 rtl/hud_card_addr_gen_flip_fsm.sv | 102 ++++++++++
 rtl/hud_card_addr_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hud_card_addr_gen_pkg.sv
// Shared types, geometry defaults and width helpers for the HUD card address generator.
//   DEF_*        : default card / HUD geometry in pixels
//   flip_state_t : per-player card-flip animation state
//   addr_w()     : BRAM address width needed for a 2-image texture strip
//   idx_w()      : index width for n items, minimum 1 bit
package hud_pkg;

  localparam int unsigned DEF_CARD_W    = 60;
  localparam int unsigned DEF_CARD_H    = 120;
  localparam int unsigned DEF_HUD_Y0    = 360;
  localparam int unsigned DEF_GRP_X0    = 60;
  localparam int unsigned DEF_GRP_PITCH = 340;
  localparam int unsigned DEF_FLIP_STEP = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHRINK,
    GROW
  } flip_state_t;

  // The strip is 2*card_w texels wide and card_h texels tall.
  function automatic int unsigned addr_w(input int unsigned card_w, input int unsigned card_h);
    return (card_h * 2 * card_w <= 1) ? 1 : $clog2(card_h * 2 * card_w);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hud_card_addr_gen_if.sv
// Pixel-in / texture-address-out bus of the HUD card address generator.
//   master : timing side (drives pixel position, frame pulse, slot mask; receives addresses)
//   slave  : address generator
interface hud_card_addr_gen_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_SLOTS   = 3,
  parameter int unsigned ADDR_W      = 14
);
  localparam int unsigned PW = hud_pkg::idx_w(NUM_PLAYERS);
  localparam int unsigned SW = hud_pkg::idx_w(NUM_SLOTS);
  localparam int unsigned NM = NUM_PLAYERS * NUM_SLOTS;

  logic              frame_start;
  logic              pix_valid;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [NM-1:0]     slot_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic              is_active;
  logic [PW-1:0]     out_player;
  logic [SW-1:0]     out_slot;
  logic              out_valid;
  logic [NUM_PLAYERS-1:0] anim_busy;

  modport master (
    output frame_start, pix_valid, h_cnt, v_cnt, slot_mask,
    input  mem_addr, is_active, out_player, out_slot, out_valid, anim_busy
  );

  modport slave (
    input  frame_start, pix_valid, h_cnt, v_cnt, slot_mask,
    output mem_addr, is_active, out_player, out_slot, out_valid, anim_busy
  );

endinterface

// File: rtl/hud_card_addr_gen_flip_fsm.sv
// Per-player card-flip animation: IDLE -> SHRINK -> GROW -> IDLE, one step per frame.
//   i_step   : frame_start pulse
//   i_pend   : this player's pending mask bits
//   i_disp   : this player's displayed mask bits
//   o_hw     : current half-width of cropped cards
//   o_chg    : slots being flipped (captured at SHRINK entry)
//   o_busy   : animation in progress
//   o_load_c : copy pending into displayed on this edge
module hud_flip_fsm
  import hud_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned CARD_W    = DEF_CARD_W,
  parameter int unsigned FLIP_STEP = DEF_FLIP_STEP,
  parameter int unsigned HW_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_step,
  input  logic [NUM_SLOTS-1:0] i_pend,
  input  logic [NUM_SLOTS-1:0] i_disp,
  output logic [HW_W-1:0]      o_hw,
  output logic [NUM_SLOTS-1:0] o_chg,
  output logic                 o_busy,
  output logic                 o_load_c
);

  localparam logic [HW_W-1:0] HALF = HW_W'(CARD_W / 2);
  localparam logic [HW_W-1:0] STEP = HW_W'(FLIP_STEP);

  flip_state_t          r_state, w_state;
  logic [HW_W-1:0]      r_hw, w_hw;
  logic [NUM_SLOTS-1:0] r_chg, w_chg;
  logic                 r_busy, w_busy;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hw    <= HALF;
      r_chg   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_hw    <= w_hw;
      r_chg   <= w_chg;
      r_busy  <= w_busy;
    end
  end

  // Next state; GROW exit re-enters SHRINK directly when more changes are pending
  always_comb begin
    w_state  = r_state;
    w_hw     = r_hw;
    w_chg    = r_chg;
    o_load_c = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_step && (i_pend != i_disp)) begin
          w_state = SHRINK;
          w_hw    = HALF - STEP;
          w_chg   = i_pend ^ i_disp;
        end
      end
      SHRINK: begin
        if (i_step) begin
          w_hw = r_hw - STEP;
          if (r_hw == STEP) begin
            o_load_c = 1'b1;
            w_state  = GROW;
          end
        end
      end
      GROW: begin
        if (i_step) begin
          w_hw = r_hw + STEP;
          if (w_hw == HALF) begin
            if (i_pend != i_disp) begin
              w_state = SHRINK;
              w_hw    = HALF - STEP;
              w_chg   = i_pend ^ i_disp;
            end else begin
              w_state = IDLE;
              w_chg   = '0;
            end
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_hw    = HALF;
        w_chg   = '0;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  assign o_hw   = r_hw;
  assign o_chg  = r_chg;
  assign o_busy = r_busy;

endmodule

// File: rtl/hud_card_addr_gen.sv
// HUD card texture address generator: maps (h_cnt, v_cnt) to a card BRAM address in
// a 2-stage pipeline, with frame-synchronous per-slot left/right image selection.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : slave side of hud_card_addr_gen_if (pixel in, address/flags out)
// Optional card-flip reveal animation enabled with `define HUD_FLIP_ANIM_EN.
module hud_card_addr_gen
  import hud_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_SLOTS   = 3,
  parameter int unsigned CARD_W      = DEF_CARD_W,
  parameter int unsigned CARD_H      = DEF_CARD_H,
  parameter int unsigned HUD_Y0      = DEF_HUD_Y0,
  parameter int unsigned GRP_X0      = DEF_GRP_X0,
  parameter int unsigned GRP_PITCH   = DEF_GRP_PITCH,
  parameter int unsigned ADDR_W      = addr_w(DEF_CARD_W, DEF_CARD_H),
  parameter int unsigned FLIP_STEP   = DEF_FLIP_STEP
) (
  input logic               clk,
  input logic               rst_n,
  hud_card_addr_gen_if.slave bus
);

  localparam int unsigned NM  = NUM_PLAYERS * NUM_SLOTS;
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam int unsigned PW  = idx_w(NUM_PLAYERS);
  localparam int unsigned SW  = idx_w(NUM_SLOTS);

  // Elaboration-time parameter sanity
  if (((CARD_W / 2) % FLIP_STEP) != 0) begin : g_bad_flip_step
    $error("CARD_W/2 must be a multiple of FLIP_STEP");
  end
  if (ADDR_W < addr_w(CARD_W, CARD_H)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for the texture strip");
  end

  logic [NM-1:0] r_pend, r_disp;

`ifdef HUD_FLIP_ANIM_EN
  localparam int unsigned HALF = CARD_W / 2;
  localparam int unsigned HW_W = idx_w(HALF + 1);

  logic [HW_W-1:0]        w_hw  [NUM_PLAYERS];
  logic [NUM_SLOTS-1:0]   w_chg [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_busy, w_load;

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_flip
    hud_flip_fsm #(
      .NUM_SLOTS(NUM_SLOTS), .CARD_W(CARD_W), .FLIP_STEP(FLIP_STEP), .HW_W(HW_W)
    ) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_step   (bus.frame_start),
      .i_pend   (r_pend[gp*NUM_SLOTS +: NUM_SLOTS]),
      .i_disp   (r_disp[gp*NUM_SLOTS +: NUM_SLOTS]),
      .o_hw     (w_hw[gp]),
      .o_chg    (w_chg[gp]),
      .o_busy   (w_busy[gp]),
      .o_load_c (w_load[gp])
    );
  end
  assign bus.anim_busy = w_busy;
`else
  assign bus.anim_busy = '0;
`endif

  // Pending mask follows slot_mask at frame_start; displayed mask lags one step behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_disp <= '0;
    end else begin
      if (bus.frame_start) r_pend <= bus.slot_mask;
`ifdef HUD_FLIP_ANIM_EN
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_load[p]) r_disp[p*NUM_SLOTS +: NUM_SLOTS] <= r_pend[p*NUM_SLOTS +: NUM_SLOTS];
      end
`else
      if (bus.frame_start) r_disp <= r_pend;
`endif
    end
  end

  // Stage 1 decode; descending loops so the lowest overlapping group wins
  logic           w_vin, w_hit, w_right;
  logic [PW-1:0]  w_player;
  logic [SW-1:0]  w_slot;
  logic [AW1-1:0] w_h, w_lx, w_ly;

  always_comb begin
    w_hit    = 1'b0;
    w_right  = 1'b0;
    w_player = '0;
    w_slot   = '0;
    w_lx     = '0;
    w_h      = AW1'(bus.h_cnt);
    w_ly     = AW1'(bus.v_cnt) - AW1'(HUD_Y0);
    w_vin    = bus.pix_valid && (AW1'(bus.v_cnt) >= AW1'(HUD_Y0)) &&
               (AW1'(bus.v_cnt) < AW1'(HUD_Y0 + CARD_H));
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
        if (w_vin && (w_h >= AW1'(GRP_X0 + p*GRP_PITCH + s*CARD_W)) &&
            (w_h < AW1'(GRP_X0 + p*GRP_PITCH + (s + 1)*CARD_W))) begin
          w_hit    = 1'b1;
          w_player = PW'(p);
          w_slot   = SW'(s);
          w_lx     = w_h - AW1'(GRP_X0 + p*GRP_PITCH + s*CARD_W);
          w_right  = r_disp[p*NUM_SLOTS + s];
`ifdef HUD_FLIP_ANIM_EN
          // Flipping slots show only the centred window of width 2*hw
          if (w_chg[p][s] && !((w_lx >= AW1'(HALF) - AW1'(w_hw[p])) &&
                               (w_lx <  AW1'(HALF) + AW1'(w_hw[p])))) begin
            w_hit = 1'b0;
          end
`endif
        end
      end
    end
  end

  logic           r_s1_valid, r_s1_hit, r_s1_right;
  logic [PW-1:0]  r_s1_player;
  logic [SW-1:0]  r_s1_slot;
  logic [AW1-1:0] r_s1_lx, r_s1_ly;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_is_active, r_out_valid;
  logic [PW-1:0]     r_out_player;
  logic [SW-1:0]     r_out_slot;

  logic [AW1-1:0] w_addr;
  assign w_addr = (r_s1_ly * AW1'(2 * CARD_W)) + (r_s1_right ? AW1'(CARD_W) : AW1'(0)) + r_s1_lx;

  // Two-stage pixel pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_hit     <= 1'b0;
      r_s1_right   <= 1'b0;
      r_s1_player  <= '0;
      r_s1_slot    <= '0;
      r_s1_lx      <= '0;
      r_s1_ly      <= '0;
      r_mem_addr   <= '0;
      r_is_active  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_player <= '0;
      r_out_slot   <= '0;
    end else begin
      r_s1_valid   <= bus.pix_valid;
      r_s1_hit     <= w_hit;
      r_s1_right   <= w_right;
      r_s1_player  <= w_hit ? w_player : '0;
      r_s1_slot    <= w_hit ? w_slot : '0;
      r_s1_lx      <= w_lx;
      r_s1_ly      <= w_ly;
      r_out_valid  <= r_s1_valid;
      r_is_active  <= r_s1_hit;
      r_mem_addr   <= r_s1_hit ? ADDR_W'(w_addr) : '0;
      r_out_player <= r_s1_player;
      r_out_slot   <= r_s1_slot;
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.is_active  = r_is_active;
  assign bus.out_player = r_out_player;
  assign bus.out_slot   = r_out_slot;
  assign bus.out_valid  = r_out_valid;

endmodule
